// File: rtl/regf_wb_sched_pkg.sv
// -----------------------------------------------------------------------------
// regf_wb_sched_pkg
// Shared constants and types for the register-file write-back scheduler.
//   WB_ALU / WB_LSU : identifiers of the two write-back requesters
//   REG_ZERO/REG_PC : registers that are never tracked and never written
// -----------------------------------------------------------------------------
package regf_wb_sched_pkg;

    localparam int unsigned REG_ZERO = 0;
    localparam int unsigned REG_PC   = 63;

    // Requester identity; also the encoding of the round-robin pointer.
    typedef enum logic {
        WB_ALU = 1'b0,
        WB_LSU = 1'b1
    } wb_sel_e;

    // True for the two architectural registers excluded from tracking and writes.
    function automatic logic is_fixed_reg(input int unsigned addr);
        return (addr == REG_ZERO) || (addr == REG_PC);
    endfunction

endpackage

// File: rtl/regf_wb_sched_rr_arb2.sv
// -----------------------------------------------------------------------------
// rr_arb2
// Two-way round-robin arbiter. A lone requester is granted at once; under
// contention the requester named by the pointer wins and the pointer then
// moves to the loser, so continuous contention alternates 0,1,0,1...
//   i_clk, i_rst     : clock, synchronous active-high reset (pointer -> WB_ALU)
//   i_req0, i_req1   : requests
//   o_gnt0, o_gnt1   : one-hot (or zero) grants, combinational
// -----------------------------------------------------------------------------
module rr_arb2
    import regf_wb_sched_pkg::*;
(
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_req0,
    input  logic i_req1,
    output logic o_gnt0,
    output logic o_gnt1
);

    wb_sel_e r_ptr;
    logic    w_contend;

    assign w_contend = i_req0 && i_req1;
    assign o_gnt0    = i_req0 && (!i_req1 || (r_ptr == WB_ALU));
    assign o_gnt1    = i_req1 && (!i_req0 || (r_ptr == WB_LSU));

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_ptr <= WB_ALU;
        end else if (w_contend) begin
            // Only a contended grant moves the pointer; lone grants leave it.
            r_ptr <= (r_ptr == WB_ALU) ? WB_LSU : WB_ALU;
        end
    end

endmodule

// File: rtl/regf_wb_sched.sv
// -----------------------------------------------------------------------------
// regf_wb_sched
// Write-back scheduler and hazard scoreboard for the register file.
// Shares the single regf write port between the ALU (wb0) and LSU (wb1),
// tracks registers with an outstanding write and stalls issue on RAW/WAW.
//   i_clk, i_rst                  : clock, synchronous active-high reset
//   i_iss_*                       : issue-stage instruction (sources, dest)
//   o_iss_ready                   : no hazard; issue accepted when valid
//   i_wb0_* / o_wb0_ready         : ALU write-back request / grant
//   i_wb1_* / o_wb1_ready         : LSU write-back request / grant
//   o_we, o_waddr, o_wdata        : registered regf write port
//   o_busy                        : scoreboard, bit n = write to reg n pending
//   o_orphan                      : sticky, write-back to a non-busy register
// -----------------------------------------------------------------------------
module regf_wb_sched
    import regf_wb_sched_pkg::*;
#(
    parameter int DW = 32,
    parameter int AW = 6
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_iss_valid,
    input  logic [AW-1:0]     i_iss_rs0,
    input  logic [AW-1:0]     i_iss_rs1,
    input  logic [AW-1:0]     i_iss_rs2,
    input  logic [AW-1:0]     i_iss_rd,
    input  logic              i_iss_wen,
    output logic              o_iss_ready,
    input  logic              i_wb0_valid,
    input  logic [AW-1:0]     i_wb0_addr,
    input  logic [DW-1:0]     i_wb0_data,
    output logic              o_wb0_ready,
    input  logic              i_wb1_valid,
    input  logic [AW-1:0]     i_wb1_addr,
    input  logic [DW-1:0]     i_wb1_data,
    output logic              o_wb1_ready,
    output logic              o_we,
    output logic [AW-1:0]     o_waddr,
    output logic [DW-1:0]     o_wdata,
    output logic [(1<<AW)-1:0] o_busy,
    output logic              o_orphan
);

    localparam int NREG = 1 << AW;

    logic [NREG-1:0] r_busy;
    logic [NREG-1:0] w_busy_nxt;
    logic            r_we;
    logic [AW-1:0]   r_waddr;
    logic [DW-1:0]   r_wdata;
    logic            r_orphan;

    logic            w_gnt0;
    logic            w_gnt1;
    logic            w_gnt_any;
    logic [AW-1:0]   w_gnt_addr;
    logic [DW-1:0]   w_gnt_data;
    logic            w_gnt_fixed;
    logic            w_iss_fire;

    rr_arb2 u_arb (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_req0 (i_wb0_valid),
        .i_req1 (i_wb1_valid),
        .o_gnt0 (w_gnt0),
        .o_gnt1 (w_gnt1)
    );

    assign w_gnt_any   = w_gnt0 || w_gnt1;
    assign w_gnt_addr  = w_gnt1 ? i_wb1_addr : i_wb0_addr;
    assign w_gnt_data  = w_gnt1 ? i_wb1_data : i_wb0_data;
    assign w_gnt_fixed = is_fixed_reg(32'(w_gnt_addr));

    // Hazard check reads the registered scoreboard only: a bit clearing on
    // this edge still stalls (no bypass).
    assign o_iss_ready = !r_busy[i_iss_rs0] && !r_busy[i_iss_rs1] && !r_busy[i_iss_rs2]
                      && !(i_iss_wen && r_busy[i_iss_rd]);
    assign w_iss_fire  = i_iss_valid && o_iss_ready;

    // NOTE: combinational blocks use blocking assignments and start from a
    // full default, so no path leaves a bit unassigned and no latch is inferred.
    always_comb begin
        w_busy_nxt = r_busy;
        // Retire the write the regf performs at this edge.
        if (r_we) begin
            w_busy_nxt[r_waddr] = 1'b0;
        end
        // Set after clear so a same-edge set wins.
        if (w_iss_fire && i_iss_wen) begin
            w_busy_nxt[i_iss_rd] = 1'b1;
        end
        w_busy_nxt[REG_ZERO] = 1'b0;
        w_busy_nxt[REG_PC]   = 1'b0;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            // Reset also drops any write waiting in the output stage.
            r_busy   <= '0;
            r_we     <= 1'b0;
            r_waddr  <= '0;
            r_wdata  <= '0;
            r_orphan <= 1'b0;
        end else begin
            r_busy <= w_busy_nxt;
            // Writes to REG_ZERO/REG_PC are granted but suppressed at the port.
            r_we   <= w_gnt_any && !w_gnt_fixed;
            if (w_gnt_any) begin
                r_waddr <= w_gnt_addr;
                r_wdata <= w_gnt_data;
            end
            if (w_gnt_any && !w_gnt_fixed && !r_busy[w_gnt_addr]) begin
                r_orphan <= 1'b1;
            end
        end
    end

    assign o_wb0_ready = w_gnt0;
    assign o_wb1_ready = w_gnt1;
    assign o_we        = r_we;
    assign o_waddr     = r_waddr;
    assign o_wdata     = r_wdata;
    assign o_busy      = r_busy;
    assign o_orphan    = r_orphan;

endmodule

// File: tb/tb_regf_wb_sched.sv
// -----------------------------------------------------------------------------
// tb_regf_wb_sched
// Self-checking bench for regf_wb_sched: directed sequences, two stimulus
// tables, then randomized traffic against a behavioural model.
// -----------------------------------------------------------------------------
module tb_regf_wb_sched;

    localparam int DW = 32;
    localparam int AW = 6;

    logic          i_clk = 1'b0;
    logic          i_rst;
    logic          i_iss_valid;
    logic [AW-1:0] i_iss_rs0, i_iss_rs1, i_iss_rs2, i_iss_rd;
    logic          i_iss_wen;
    logic          o_iss_ready;
    logic          i_wb0_valid;
    logic [AW-1:0] i_wb0_addr;
    logic [DW-1:0] i_wb0_data;
    logic          o_wb0_ready;
    logic          i_wb1_valid;
    logic [AW-1:0] i_wb1_addr;
    logic [DW-1:0] i_wb1_data;
    logic          o_wb1_ready;
    logic          o_we;
    logic [AW-1:0] o_waddr;
    logic [DW-1:0] o_wdata;
    logic [63:0]   o_busy;
    logic          o_orphan;

    regf_wb_sched #(.DW(DW), .AW(AW)) dut (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_iss_valid (i_iss_valid),
        .i_iss_rs0   (i_iss_rs0),
        .i_iss_rs1   (i_iss_rs1),
        .i_iss_rs2   (i_iss_rs2),
        .i_iss_rd    (i_iss_rd),
        .i_iss_wen   (i_iss_wen),
        .o_iss_ready (o_iss_ready),
        .i_wb0_valid (i_wb0_valid),
        .i_wb0_addr  (i_wb0_addr),
        .i_wb0_data  (i_wb0_data),
        .o_wb0_ready (o_wb0_ready),
        .i_wb1_valid (i_wb1_valid),
        .i_wb1_addr  (i_wb1_addr),
        .i_wb1_data  (i_wb1_data),
        .o_wb1_ready (o_wb1_ready),
        .o_we        (o_we),
        .o_waddr     (o_waddr),
        .o_wdata     (o_wdata),
        .o_busy      (o_busy),
        .o_orphan    (o_orphan)
    );

    always #5 i_clk = ~i_clk;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Advance to just after the next rising edge; inputs change here.
    task automatic cyc();
        @(posedge i_clk);
        #1;
    endtask

    // Let combinational outputs settle before sampling (well before next edge).
    task automatic settle();
        #2;
    endtask

    task automatic clear_inputs();
        i_iss_valid = 1'b0;
        i_iss_rs0 = '0; i_iss_rs1 = '0; i_iss_rs2 = '0; i_iss_rd = '0;
        i_iss_wen = 1'b0;
        i_wb0_valid = 1'b0; i_wb0_addr = '0; i_wb0_data = '0;
        i_wb1_valid = 1'b0; i_wb1_addr = '0; i_wb1_data = '0;
    endtask

    task automatic do_reset();
        clear_inputs();
        i_rst = 1'b1;
        cyc();
        i_rst = 1'b0;
    endtask

    task automatic issue(input logic [5:0] rd);
        i_iss_valid = 1'b1; i_iss_wen = 1'b1; i_iss_rd = rd;
        i_iss_rs0 = 6'd0; i_iss_rs1 = 6'd0; i_iss_rs2 = 6'd0;
    endtask

    function automatic logic [5:0] rand_addr();
        int r;
        r = $urandom_range(0, 19);
        if (r < 16) return 6'(r);
        return 6'(63 - (r - 16));
    endfunction

    function automatic bit tracked(input logic [5:0] a);
        return (a != 6'd0) && (a != 6'd63);
    endfunction

    // Arbitration / output-stage table: ewe/ewaddr/ewdata are the port values
    // expected in the cycle the row is applied (result of the previous row).
    typedef struct {
        logic v0; logic [5:0] a0; logic [31:0] d0;
        logic v1; logic [5:0] a1; logic [31:0] d1;
        logic eg0; logic eg1;
        logic ewe; logic [5:0] ewaddr; logic [31:0] ewdata;
    } arb_vec_t;

    typedef struct {
        logic [5:0] rs0; logic [5:0] rs1; logic [5:0] rs2; logic [5:0] rd;
        logic wen; logic erdy;
    } haz_vec_t;

    arb_vec_t arb_tab[7];
    haz_vec_t haz_tab[8];

    // Behavioural reference state for the random phase.
    logic [63:0] bm;
    int          fav;
    bit          m_we;
    logic [5:0]  m_waddr;
    logic [31:0] m_wdata;
    bit          m_orph;

    initial begin
        localparam logic [31:0] DA = 32'hA000_0007;
        localparam logic [31:0] DB = 32'hB000_0008;

        arb_tab[0] = '{1'b1, 6'd7, DA, 1'b1, 6'd8, DB, 1'b1, 1'b0, 1'b0, 6'd0, 32'd0};
        arb_tab[1] = '{1'b1, 6'd7, DA, 1'b1, 6'd8, DB, 1'b0, 1'b1, 1'b1, 6'd7, DA};
        arb_tab[2] = '{1'b1, 6'd7, DA, 1'b1, 6'd8, DB, 1'b1, 1'b0, 1'b1, 6'd8, DB};
        arb_tab[3] = '{1'b1, 6'd7, DA, 1'b1, 6'd8, DB, 1'b0, 1'b1, 1'b1, 6'd7, DA};
        arb_tab[4] = '{1'b0, 6'd7, DA, 1'b1, 6'd8, DB, 1'b0, 1'b1, 1'b1, 6'd8, DB};
        arb_tab[5] = '{1'b0, 6'd0, 32'd0, 1'b0, 6'd0, 32'd0, 1'b0, 1'b0, 1'b1, 6'd8, DB};
        arb_tab[6] = '{1'b0, 6'd0, 32'd0, 1'b0, 6'd0, 32'd0, 1'b0, 1'b0, 1'b0, 6'd8, DB};

        // Busy set = {10, 20}.
        haz_tab[0] = '{6'd1,  6'd2,  6'd3,  6'd4,  1'b1, 1'b1};
        haz_tab[1] = '{6'd10, 6'd2,  6'd3,  6'd4,  1'b1, 1'b0};
        haz_tab[2] = '{6'd1,  6'd20, 6'd3,  6'd4,  1'b0, 1'b0};
        haz_tab[3] = '{6'd1,  6'd2,  6'd20, 6'd4,  1'b1, 1'b0};
        haz_tab[4] = '{6'd1,  6'd2,  6'd3,  6'd10, 1'b1, 1'b0};
        haz_tab[5] = '{6'd1,  6'd2,  6'd3,  6'd10, 1'b0, 1'b1};
        haz_tab[6] = '{6'd0,  6'd63, 6'd0,  6'd63, 1'b1, 1'b1};
        haz_tab[7] = '{6'd11, 6'd21, 6'd9,  6'd30, 1'b1, 1'b1};

        clear_inputs();
        i_rst = 1'b1;
        cyc();
        cyc();
        i_rst = 1'b0;

        // ---- reset then idle ----
        i_iss_rs0 = 6'd5; i_iss_rs1 = 6'd5; i_iss_rs2 = 6'd5; i_iss_rd = 6'd5; i_iss_wen = 1'b1;
        settle();
        check("rst_busy",   o_busy, 64'd0);
        check("rst_we",     o_we, 1'b0);
        check("rst_waddr",  o_waddr, 6'd0);
        check("rst_wdata",  o_wdata, 32'd0);
        check("rst_orphan", o_orphan, 1'b0);
        check("rst_ready",  o_iss_ready, 1'b1);

        // ---- RAW stall and write-back release ----
        do_reset();
        issue(6'd5); i_iss_rs0 = 6'd1; i_iss_rs1 = 6'd2; i_iss_rs2 = 6'd3;
        settle();
        check("raw_c1_ready", o_iss_ready, 1'b1);
        cyc();
        clear_inputs(); i_iss_valid = 1'b1; i_iss_rs0 = 6'd5;
        settle();
        check("raw_c2_busy",  o_busy, 64'd1 << 5);
        check("raw_c2_ready", o_iss_ready, 1'b0);
        cyc();
        i_wb0_valid = 1'b1; i_wb0_addr = 6'd5; i_wb0_data = 32'hDEAD_BEEF;
        settle();
        check("raw_c3_gnt0", o_wb0_ready, 1'b1);
        check("raw_c3_we",   o_we, 1'b0);
        cyc();
        i_wb0_valid = 1'b0;
        settle();
        check("raw_c4_we",    o_we, 1'b1);
        check("raw_c4_waddr", o_waddr, 6'd5);
        check("raw_c4_wdata", o_wdata, 32'hDEAD_BEEF);
        check("raw_c4_ready_nobypass", o_iss_ready, 1'b0);
        cyc();
        settle();
        check("raw_c5_busy",   o_busy, 64'd0);
        check("raw_c5_ready",  o_iss_ready, 1'b1);
        check("raw_c5_we",     o_we, 1'b0);
        check("raw_c5_orphan", o_orphan, 1'b0);

        // ---- hazard table ----
        do_reset();
        issue(6'd10);
        cyc();
        issue(6'd20);
        cyc();
        clear_inputs();
        settle();
        check("haz_busy", o_busy, (64'd1 << 10) | (64'd1 << 20));
        for (int i = 0; i < 8; i++) begin
            i_iss_rs0 = haz_tab[i].rs0; i_iss_rs1 = haz_tab[i].rs1;
            i_iss_rs2 = haz_tab[i].rs2; i_iss_rd  = haz_tab[i].rd;
            i_iss_wen = haz_tab[i].wen;
            settle();
            check($sformatf("haz_tab[%0d]_ready", i), o_iss_ready, haz_tab[i].erdy);
            cyc();
        end

        // ---- contention table ----
        do_reset();
        for (int i = 0; i < 7; i++) begin
            i_wb0_valid = arb_tab[i].v0; i_wb0_addr = arb_tab[i].a0; i_wb0_data = arb_tab[i].d0;
            i_wb1_valid = arb_tab[i].v1; i_wb1_addr = arb_tab[i].a1; i_wb1_data = arb_tab[i].d1;
            settle();
            check($sformatf("arb_tab[%0d]_gnt0", i),  o_wb0_ready, arb_tab[i].eg0);
            check($sformatf("arb_tab[%0d]_gnt1", i),  o_wb1_ready, arb_tab[i].eg1);
            check($sformatf("arb_tab[%0d]_we", i),    o_we, arb_tab[i].ewe);
            check($sformatf("arb_tab[%0d]_waddr", i), o_waddr, arb_tab[i].ewaddr);
            check($sformatf("arb_tab[%0d]_wdata", i), o_wdata, arb_tab[i].ewdata);
            cyc();
        end

        // ---- REG_ZERO / REG_PC exclusion ----
        do_reset();
        issue(6'd0);
        settle();
        check("fix_rd0_ready", o_iss_ready, 1'b1);
        cyc();
        issue(6'd63);
        cyc();
        clear_inputs();
        settle();
        check("fix_busy", o_busy, 64'd0);
        i_wb1_valid = 1'b1; i_wb1_addr = 6'd63; i_wb1_data = 32'h0000_5A5A;
        settle();
        check("fix_gnt1", o_wb1_ready, 1'b1);
        cyc();
        clear_inputs();
        settle();
        check("fix_we",     o_we, 1'b0);
        check("fix_waddr",  o_waddr, 6'd63);
        check("fix_wdata",  o_wdata, 32'h0000_5A5A);
        check("fix_orphan", o_orphan, 1'b0);

        // ---- orphan write-back ----
        do_reset();
        i_wb0_valid = 1'b1; i_wb0_addr = 6'd9; i_wb0_data = 32'h1234_5678;
        settle();
        check("orph_pre", o_orphan, 1'b0);
        cyc();
        clear_inputs();
        settle();
        check("orph_we",    o_we, 1'b1);
        check("orph_waddr", o_waddr, 6'd9);
        check("orph_flag",  o_orphan, 1'b1);
        repeat (3) cyc();
        settle();
        check("orph_sticky", o_orphan, 1'b1);
        do_reset();
        settle();
        check("orph_cleared", o_orphan, 1'b0);

        // ---- reset discards a granted write and the pointer ----
        do_reset();
        issue(6'd4);
        cyc();
        clear_inputs();
        i_wb0_valid = 1'b1; i_wb0_addr = 6'd3; i_wb0_data = 32'h3333_3333;
        i_wb1_valid = 1'b1; i_wb1_addr = 6'd4; i_wb1_data = 32'h4444_4444;
        settle();
        check("rr_pre_gnt0", o_wb0_ready, 1'b1);
        cyc();
        i_wb0_valid = 1'b0;
        settle();
        check("rr_lone_gnt1", o_wb1_ready, 1'b1);
        i_rst = 1'b1;
        cyc();
        i_rst = 1'b0;
        i_wb0_valid = 1'b1;
        settle();
        check("rr_post_we",   o_we, 1'b0);
        check("rr_post_busy", o_busy, 64'd0);
        check("rr_post_gnt0", o_wb0_ready, 1'b1);
        check("rr_post_gnt1", o_wb1_ready, 1'b0);

        // ---- randomized traffic against the model ----
        do_reset();
        bm = '0; fav = 0; m_we = 1'b0; m_waddr = '0; m_wdata = '0; m_orph = 1'b0;
        begin
            bit p0 = 1'b0, p1 = 1'b0;
            logic [5:0]  pa0 = '0, pa1 = '0;
            logic [31:0] pd0 = '0, pd1 = '0;
            for (int c = 0; c < 2000; c++) begin
                int          win;
                bit          exp_rdy;
                logic [5:0]  ga;
                logic [31:0] gd;
                if (!p0 && $urandom_range(0, 9) < 6) begin p0 = 1'b1; pa0 = rand_addr(); pd0 = $urandom; end
                if (!p1 && $urandom_range(0, 9) < 6) begin p1 = 1'b1; pa1 = rand_addr(); pd1 = $urandom; end
                i_wb0_valid = p0; i_wb0_addr = pa0; i_wb0_data = pd0;
                i_wb1_valid = p1; i_wb1_addr = pa1; i_wb1_data = pd1;
                i_iss_valid = 1'($urandom_range(0, 1));
                i_iss_wen   = 1'($urandom_range(0, 1));
                i_iss_rs0 = rand_addr(); i_iss_rs1 = rand_addr();
                i_iss_rs2 = rand_addr(); i_iss_rd  = rand_addr();
                settle();

                exp_rdy = !bm[i_iss_rs0] && !bm[i_iss_rs1] && !bm[i_iss_rs2]
                       && !(i_iss_wen && bm[i_iss_rd]);
                if (p0 && p1)  win = fav;
                else if (p0)   win = 0;
                else if (p1)   win = 1;
                else           win = -1;

                check("rnd_ready",  o_iss_ready, exp_rdy);
                check("rnd_gnt0",   o_wb0_ready, win == 0);
                check("rnd_gnt1",   o_wb1_ready, win == 1);
                check("rnd_we",     o_we, m_we);
                check("rnd_waddr",  o_waddr, m_waddr);
                check("rnd_wdata",  o_wdata, m_wdata);
                check("rnd_busy",   o_busy, bm);
                check("rnd_orphan", o_orphan, m_orph);

                ga = (win == 1) ? pa1 : pa0;
                gd = (win == 1) ? pd1 : pd0;
                if (win >= 0 && tracked(ga) && !bm[ga]) m_orph = 1'b1;
                if (m_we) bm[m_waddr] = 1'b0;
                if (i_iss_valid && exp_rdy && i_iss_wen && tracked(i_iss_rd)) bm[i_iss_rd] = 1'b1;
                if (win >= 0) begin
                    m_we = tracked(ga); m_waddr = ga; m_wdata = gd;
                end else begin
                    m_we = 1'b0;
                end
                if (p0 && p1) fav = 1 - win;
                if (win == 0) p0 = 1'b0;
                if (win == 1) p1 = 1'b0;
                cyc();
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
